// File: rtl/edge_pkg.sv
// edge_pkg: shared state encoding, default geometry and width helper for the edge output packer.
package edge_pkg;
    typedef enum logic {FILL, SEND} state_t;
    localparam int DEF_IMG_WIDTH = 720;
    localparam int DEF_IMG_HEIGHT = 540;
    localparam int DEF_PIX_PER_WORD = 4;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: column/row position of the next popped pixel, with last-column/last-row flags.
module frame_pos_counter import edge_pkg::*; #(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             adv,
    output logic [cnt_w(IMG_WIDTH)-1:0]      col,
    output logic [cnt_w(IMG_HEIGHT)-1:0]     row,
    output logic                             last_col,
    output logic                             last_row
);
    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);
    assign last_col = col == CW'(IMG_WIDTH - 1);
    assign last_row = row == RW'(IMG_HEIGHT - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
        end
    end
endmodule

// File: rtl/edge_out_packer.sv
// edge_out_packer: packs 8-bit edge pixels from a show-ahead FIFO into tagged words with a valid/ready handshake.
module edge_out_packer import edge_pkg::*; #(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        img_rd_en,
    input  logic                        img_empty,
    input  logic [7:0]                  img_dout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*PIX_PER_WORD-1:0]   out_data,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic                        out_eof,
    output logic                        frame_done
);
    localparam int FW = cnt_w(PIX_PER_WORD);
    state_t state;
    logic [FW-1:0] fill_cnt;
    logic [cnt_w(IMG_WIDTH)-1:0] col;
    logic [cnt_w(IMG_HEIGHT)-1:0] row;
    logic last_col, last_row, last_lane;
    // Gating with reset keeps a pixel in the FIFO when reset and a pop coincide.
    assign img_rd_en = !reset && state == FILL && !img_empty;
    assign frame_done = !reset && out_valid && out_ready && out_eof;
    assign last_lane = fill_cnt == FW'(PIX_PER_WORD - 1);
    frame_pos_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) pos (
        .clock(clock),
        .reset(reset),
        .adv(img_rd_en),
        .col(col),
        .row(row),
        .last_col(last_col),
        .last_row(last_row)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
            fill_cnt <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_sof <= 1'b0;
            out_eol <= 1'b0;
            out_eof <= 1'b0;
        end else if (state == FILL) begin
            if (img_rd_en) begin
                out_data[8*fill_cnt +: 8] <= img_dout;
                if (fill_cnt == '0) out_sof <= col == '0 && row == '0;
                if (last_lane) begin
                    fill_cnt <= '0;
                    state <= SEND;
                    out_valid <= 1'b1;
                    out_eol <= last_col;
                    out_eof <= last_col && last_row;
                end else begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end else if (out_ready) begin
            state <= FILL;
            out_valid <= 1'b0;
        end
    end
endmodule
